regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised successor to the single-write, two-read integer register file.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports with write-to-read bypass.
- Includes a pending-write scoreboard: decode marks a destination busy and writeback clears it, so the hazard unit can stall on a busy operand.
- Sits between decode (reads, issue) and writeback (writes) of the pipeline.

Parameters:
XLEN, 32, register data width in bits
NREGS, 32, number of architectural registers (power of two, ≥ 2)
NUM_RD, 2, number of read ports
NUM_WR, 1, number of write ports (1..2)
AW, $clog2(NREGS), address width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*AW  read addresses, port i at bits [i*AW +: AW]
rd_data  out  NUM_RD*XLEN  read data per port
rd_busy  out  NUM_RD  operand pending per port
wr_en  in  NUM_WR  write enable per port
wr_addr  in  NUM_WR*AW  write addresses
wr_data  in  NUM_WR*XLEN  write data
wr_clr  in  NUM_WR  clear scoreboard bit of wr_addr on this write
iss_en  in  1  issue: mark iss_addr pending
iss_addr  in  AW  destination register being issued
pend_cnt  out  AW+1  number of registers currently marked busy

Behaviour:
- Reset (rst=0, asynchronous): all registers become 0, all busy bits become 0, and pend_cnt becomes 0. While rst=0, rd_data=0 and rd_busy=0.
- Register 0:
  - Hardwired to zero; writes to it are ignored.
  - Its busy bit is never set, and issue to address 0 is ignored.
- Writes take effect at posedge clk when wr_en[j]=1 and wr_addr[j]≠0.
- Same-cycle write conflict: when two write ports target the same address, the higher-index port wins.
- Read is combinational, with bypass:
  - If any enabled write port targets rd_addr[i]≠0 in the current cycle, rd_data[i] is that port's wr_data (highest index wins).
  - Otherwise rd_data[i] is the stored value. Zero read latency.
- Scoreboard update at posedge:
  - busy[a] is cleared when some port j has wr_en[j] & wr_clr[j] & wr_addr[j]=a.
  - busy[a] is set when iss_en & iss_addr=a≠0.
  - Set and clear of the same address in the same cycle: set wins, so the register stays busy (the new producer is pending).
- rd_busy[i] = busy[rd_addr[i]] & ~(same-cycle clearing write to rd_addr[i]). The bypass makes the value available, so no stall is raised.
- Clearing a non-busy register has no effect; there is no underflow.
- Issuing to an already-busy register leaves it busy, with no double count.
- pend_cnt: registered popcount of busy bits, updated every cycle. Range 0..NREGS-1.
- Reset asserted mid-operation: state is cleared immediately. The first posedge after rst rises behaves as a normal cycle.

Decomposition:
- Shared package rf_pkg holds:
  - RF_XLEN and RF_NREGS defaults.
  - Typedef reg_addr_t (AW bits).
  - Typedef xword_t (XLEN bits).
  - Constant REG_ZERO=0.
- One sub-module, rf_scoreboard, holds the busy vector, set/clear priority logic, rd_busy generation and pend_cnt.
- Storage and bypass mux stay in the top module.

Test Plan:
- Reset: hold rst=0, drive reads of addresses 0..31. Expect rd_data=0, rd_busy=0, pend_cnt=0. Release rst, then read addr 5 → 0x00000000.
- Write/read/bypass: write 0xDEADBEEF to x7. In the same cycle rd_addr[0]=7 → rd_data[0]=0xDEADBEEF (bypass). Next cycle with no write, a read of x7 still gives 0xDEADBEEF.
- x0 protection: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF, plus iss_en to addr 0. Next cycle read x0 → 0 and pend_cnt=0.
- Dual write conflict (NUM_WR=2): both ports write x3, with port0=0x11 and port1=0x22. Next read x3 → 0x22.
- Scoreboard:
  - Issue x9, then rd_addr=9 → rd_busy=1, pend_cnt=1.
  - In a writeback-with-clear cycle to x9, rd_busy=0 with data bypassed.
  - Next cycle pend_cnt=0.
  - Issue and clear x9 in the same cycle → stays busy, pend_cnt=1.
- Async reset mid-stream: with x4=0x55 and x6 busy, pulse rst=0 between clock edges. rd_data goes to 0 and pend_cnt goes to 0 without a clock edge. After release, read x4 → 0.

Source files
------------

// File: rtl/regfile_mp_sb_pkg.sv
// Shared definitions for the multi-port register file and its scoreboard.
package rf_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  // Address of the hardwired-zero register.
  localparam int REG_ZERO = 0;

  typedef logic [$clog2(RF_NREGS)-1:0] reg_addr_t;
  typedef logic [RF_XLEN-1:0]          xword_t;

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Pending-write scoreboard: issue marks a destination busy, writeback with
// clear releases it. Also produces per-read-port busy flags and a count of
// busy registers.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS  = RF_NREGS,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_busy,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_WR-1:0]    wr_clr,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic [AW:0]          pend_cnt
);

  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_pend_cnt;
  logic [NREGS-1:0] w_clr_vec;
  logic [NREGS-1:0] w_set_vec;
  logic [NREGS-1:0] w_busy_next;
  logic [AW:0]      w_cnt_next;

  // Decode this cycle's clears (writebacks) and set (issue) into one-hot vectors.
  always_comb begin
    w_clr_vec = '0;
    w_set_vec = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && wr_clr[j]) begin
        w_clr_vec[wr_addr[j*AW +: AW]] = 1'b1;
      end
    end
    if (iss_en && iss_addr != AW'(REG_ZERO)) begin
      w_set_vec[iss_addr] = 1'b1;
    end
  end

  // Set is applied after clear so a new producer keeps the register busy;
  // register 0 can never become busy.
  always_comb begin
    w_busy_next = (r_busy & ~w_clr_vec) | w_set_vec;
    w_busy_next[REG_ZERO] = 1'b0;
    w_cnt_next = '0;
    for (int k = 0; k < NREGS; k++) begin
      w_cnt_next = w_cnt_next + {{AW{1'b0}}, w_busy_next[k]};
    end
  end

  // Busy vector and its popcount advance together so the count always matches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_pend_cnt <= w_cnt_next;
    end
  end

  // A same-cycle clearing write is bypassed to the reader, so it is not a stall.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_busy
    logic [AW-1:0] w_addr;
    assign w_addr      = rd_addr[gi*AW +: AW];
    assign rd_busy[gi] = rst & r_busy[w_addr] & ~w_clr_vec[w_addr];
  end

  assign pend_cnt = r_pend_cnt;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file: NUM_RD combinational read ports with
// write-to-read bypass, NUM_WR write ports (higher index wins on conflict),
// hardwired-zero x0, plus a pending-write scoreboard.
module regfile_mp_sb
  import rf_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREGS  = RF_NREGS,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic [NUM_WR-1:0]      wr_clr,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  output logic [AW:0]            pend_cnt
);

  logic [XLEN-1:0] r_regs [NREGS];

  // Register writes; later ports overwrite earlier ones, x0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != AW'(REG_ZERO)) begin
          r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_val;

    assign w_addr = rd_addr[gi*AW +: AW];

    // Stored value, overridden by the highest-index write hitting this address.
    always_comb begin
      w_val = r_regs[w_addr];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == w_addr && w_addr != AW'(REG_ZERO)) begin
          w_val = wr_data[j*XLEN +: XLEN];
        end
      end
    end

    // Reads are forced to zero while reset is held, even if a write is presented.
    assign rd_data[gi*XLEN +: XLEN] = rst ? w_val : '0;
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_clr   (wr_clr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .pend_cnt (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios plus randomized
// traffic checked against an array-based reference model.
module tb_regfile_mp_sb;
  import rf_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en = '0;
  logic [NWR*AW-1:0]   wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic [NWR-1:0]      wr_clr = '0;
  logic                iss_en = 1'b0;
  logic [AW-1:0]       iss_addr = '0;
  logic [AW:0]         pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural register contents and pending flags.
  xword_t m_mem  [NREGS];
  bit     m_busy [NREGS];

  always #5 clk = ~clk;

  regfile_mp_sb #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NUM_RD (NRD),
    .NUM_WR (NWR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_clr   (wr_clr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .pend_cnt (pend_cnt)
  );

  function automatic int raddr(int i);
    return int'(rd_addr[i*AW +: AW]);
  endfunction

  function automatic int waddr(int j);
    return int'(wr_addr[j*AW +: AW]);
  endfunction

  function automatic xword_t rdata(int i);
    return rd_data[i*XLEN +: XLEN];
  endfunction

  // Expected read value: x0 is zero, the newest write of this cycle is forwarded.
  function automatic xword_t exp_data(int i);
    xword_t r;
    int a = raddr(i);
    if (!rst || a == 0) return '0;
    r = m_mem[a];
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && waddr(j) == a) r = wr_data[j*XLEN +: XLEN];
    return r;
  endfunction

  // Expected stall flag: pending and not being released right now.
  function automatic logic exp_busy(int i);
    int a = raddr(i);
    if (!rst) return 1'b0;
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && wr_clr[j] && waddr(j) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int k = 0; k < NREGS; k++) c += int'(m_busy[k]);
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREGS; k++) begin
      m_mem[k]  = '0;
      m_busy[k] = 1'b0;
    end
  endtask

  // Apply the current inputs to the model as one clock edge would.
  task automatic model_clock();
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && waddr(j) != 0) m_mem[waddr(j)] = wr_data[j*XLEN +: XLEN];
      if (wr_en[j] && wr_clr[j]) m_busy[waddr(j)] = 1'b0;
    end
    if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
  endtask

  task automatic idle();
    wr_en  = '0;
    wr_clr = '0;
    iss_en = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic drive_wr(int j, int a, xword_t d, bit clr);
    wr_en[j] = 1'b1;
    wr_addr[j*AW +: AW] = AW'(a);
    wr_data[j*XLEN +: XLEN] = d;
    wr_clr[j] = clr;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b0;
    for (int a = 0; a < NREGS; a++) begin
      rd_addr[0 +: AW]  = AW'(a);
      rd_addr[AW +: AW] = AW'(NREGS - 1 - a);
      drive_wr(0, a, $urandom, 1'b1);
      iss_en = 1'b1;
      iss_addr = AW'(a);
      #1;
      n_checks++;
      if (rd_data !== '0) begin
        n_fail++;
        $display("FAIL reset_rd_data addr=%0d got=%h want=0", a, rd_data);
      end
      n_checks++;
      if (rd_busy !== '0) begin
        n_fail++;
        $display("FAIL reset_rd_busy addr=%0d got=%b want=0", a, rd_busy);
      end
      n_checks++;
      if (pend_cnt !== '0) begin
        n_fail++;
        $display("FAIL reset_pend_cnt got=%0d want=0", pend_cnt);
      end
    end
    idle();
    @(negedge clk);
    rst = 1'b1;
    rd_addr[0 +: AW] = AW'(5);
    #1;
    n_checks++;
    if (rdata(0) !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release_x5 got=%h want=00000000", rdata(0));
    end
    $display("reset: held and released, x5=%h pend=%0d", rdata(0), pend_cnt);
  endtask

  task automatic test_write_bypass();
    next_cycle();
    drive_wr(0, 7, 32'hDEADBEEF, 1'b0);
    rd_addr[0 +: AW] = AW'(7);
    #1;
    n_checks++;
    if (rdata(0) !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL bypass_x7 got=%h want=deadbeef", rdata(0));
    end
    next_cycle();
    idle();
    #1;
    n_checks++;
    if (rdata(0) !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL stored_x7 got=%h want=deadbeef", rdata(0));
    end
    $display("write_bypass: x7=%h", rdata(0));
  endtask

  task automatic test_x0();
    next_cycle();
    drive_wr(0, 0, 32'hFFFFFFFF, 1'b0);
    iss_en = 1'b1;
    iss_addr = '0;
    rd_addr[0 +: AW] = '0;
    #1;
    n_checks++;
    if (rdata(0) !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_bypass got=%h want=00000000", rdata(0));
    end
    next_cycle();
    idle();
    #1;
    n_checks++;
    if (rdata(0) !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_read got=%h want=00000000", rdata(0));
    end
    n_checks++;
    if (pend_cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL x0_pend got=%0d want=0", pend_cnt);
    end
    $display("x0: read=%h pend=%0d", rdata(0), pend_cnt);
  endtask

  task automatic test_dual_write();
    next_cycle();
    drive_wr(0, 3, 32'h11, 1'b0);
    drive_wr(1, 3, 32'h22, 1'b0);
    rd_addr[AW +: AW] = AW'(3);
    #1;
    n_checks++;
    if (rdata(1) !== 32'h22) begin
      n_fail++;
      $display("FAIL dual_bypass_x3 got=%h want=00000022", rdata(1));
    end
    next_cycle();
    idle();
    #1;
    n_checks++;
    if (rdata(1) !== 32'h22) begin
      n_fail++;
      $display("FAIL dual_stored_x3 got=%h want=00000022", rdata(1));
    end
    $display("dual_write: x3=%h", rdata(1));
  endtask

  task automatic test_scoreboard();
    next_cycle();
    iss_en = 1'b1;
    iss_addr = AW'(9);
    next_cycle();
    idle();
    rd_addr[0 +: AW] = AW'(9);
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_issue_busy got=%b want=1", rd_busy[0]);
    end
    n_checks++;
    if (pend_cnt !== 6'd1) begin
      n_fail++;
      $display("FAIL sb_issue_pend got=%0d want=1", pend_cnt);
    end
    drive_wr(0, 9, 32'h0000ABCD, 1'b1);
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_clear_busy got=%b want=0", rd_busy[0]);
    end
    n_checks++;
    if (rdata(0) !== 32'h0000ABCD) begin
      n_fail++;
      $display("FAIL sb_clear_bypass got=%h want=0000abcd", rdata(0));
    end
    next_cycle();
    idle();
    #1;
    n_checks++;
    if (pend_cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL sb_clear_pend got=%0d want=0", pend_cnt);
    end
    iss_en = 1'b1;
    iss_addr = AW'(9);
    drive_wr(1, 9, 32'h1234, 1'b1);
    next_cycle();
    idle();
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_set_wins_busy got=%b want=1", rd_busy[0]);
    end
    n_checks++;
    if (pend_cnt !== 6'd1) begin
      n_fail++;
      $display("FAIL sb_set_wins_pend got=%0d want=1", pend_cnt);
    end
    $display("scoreboard: x9 busy=%b pend=%0d", rd_busy[0], pend_cnt);
    drive_wr(0, 9, 32'h0, 1'b1);
    next_cycle();
    idle();
  endtask

  task automatic test_random();
    int errs_before = n_fail;
    for (int n = 0; n < 400; n++) begin
      next_cycle();
      for (int i = 0; i < NRD; i++)
        rd_addr[i*AW +: AW] = AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : NREGS - 1));
      for (int j = 0; j < NWR; j++) begin
        wr_en[j] = ($urandom_range(0, 2) != 0);
        wr_addr[j*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[j*XLEN +: XLEN] = $urandom;
        wr_clr[j] = $urandom_range(0, 1) != 0;
      end
      iss_en = $urandom_range(0, 1) != 0;
      iss_addr = AW'($urandom_range(0, ($urandom_range(0, 3) == 0) ? NREGS - 1 : 7));
      #1;
      for (int i = 0; i < NRD; i++) begin
        n_checks++;
        if (rdata(i) !== exp_data(i)) begin
          n_fail++;
          $display("FAIL rand_rd_data cyc=%0d port=%0d addr=%0d got=%h want=%h",
                   n, i, raddr(i), rdata(i), exp_data(i));
        end
        n_checks++;
        if (rd_busy[i] !== exp_busy(i)) begin
          n_fail++;
          $display("FAIL rand_rd_busy cyc=%0d port=%0d addr=%0d got=%b want=%b",
                   n, i, raddr(i), rd_busy[i], exp_busy(i));
        end
      end
      n_checks++;
      if (int'(pend_cnt) != exp_cnt()) begin
        n_fail++;
        $display("FAIL rand_pend_cnt cyc=%0d got=%0d want=%0d", n, pend_cnt, exp_cnt());
      end
    end
    idle();
    $display("random: 400 cycles, %0d new failures", n_fail - errs_before);
  endtask

  task automatic test_async_reset();
    next_cycle();
    drive_wr(0, 4, 32'h55, 1'b0);
    iss_en = 1'b1;
    iss_addr = AW'(6);
    next_cycle();
    idle();
    rd_addr[0 +: AW]  = AW'(4);
    rd_addr[AW +: AW] = AW'(6);
    #1;
    n_checks++;
    if (rdata(0) !== 32'h55) begin
      n_fail++;
      $display("FAIL arst_pre_x4 got=%h want=00000055", rdata(0));
    end
    n_checks++;
    if (rd_busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre_x6_busy got=%b want=1", rd_busy[1]);
    end
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (rdata(0) !== 32'h0) begin
      n_fail++;
      $display("FAIL arst_x4 got=%h want=00000000", rdata(0));
    end
    n_checks++;
    if (pend_cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL arst_pend got=%0d want=0", pend_cnt);
    end
    n_checks++;
    if (rd_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL arst_busy got=%b want=00", rd_busy);
    end
    #1;
    rst = 1'b1;
    next_cycle();
    #1;
    n_checks++;
    if (rdata(0) !== 32'h0) begin
      n_fail++;
      $display("FAIL arst_after_x4 got=%h want=00000000", rdata(0));
    end
    n_checks++;
    if (rd_busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_after_x6_busy got=%b want=0", rd_busy[1]);
    end
    $display("async_reset: x4=%h pend=%0d", rdata(0), pend_cnt);
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_x0();
    test_dual_write();
    test_scoreboard();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
